// File: rtl/xmit_uart_tx.sv
// Generic synchronous FIFO: registered count, head word visible combinationally.
// Latency: a word written at edge N is readable from the cycle after edge N.
// Backpressure: wr_rdy low when full; no write-through on a full FIFO even if a read happens.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign wr_rdy = (count != CW'(DEPTH));
  assign rd_vld = (count != '0);
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_rdy && rd_vld;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Async serial transmitter: start, DATA_W data bits LSB first, optional parity, 1 or 2 stops.
// Latency: word pushed at edge N into an idle block shows its start bit from edge N+2.
// Backpressure: tx_ready follows FIFO space; frames chain back-to-back while words are queued.
module xmit_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int IW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic              fifo_vld;
  logic [DATA_W-1:0] fifo_dat;
  logic              pop;

  logic [DATA_W-1:0] shreg_q;
  logic [IW-1:0]     bit_idx_q;
  logic [DIV_W-1:0]  baud_cnt_q;
  logic              parity_q;
  logic [DIV_W-1:0]  div_q;
  logic              par_en_q;
  logic              two_stop_q;

  logic              bit_end;
  logic              line_d;
  logic              busy_d;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (tx_valid),
    .wr_rdy (tx_ready),
    .wr_dat (tx_data),
    .rd_vld (fifo_vld),
    .rd_rdy (pop),
    .rd_dat (fifo_dat),
    .count  (fifo_count)
  );

  assign bit_end = (baud_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every frame start, from IDLE or straight off the last stop bit, pops the FIFO head.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_vld) begin
          state_d = START;
          pop     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end && (bit_idx_q == IW'(DATA_W - 1))) begin
          state_d = par_en_q ? PARITY : STOP1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (bit_end) begin
          if (two_stop_q) begin
            state_d = STOP2;
          end else if (fifo_vld) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STOP2: begin
        if (bit_end) begin
          if (fifo_vld) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    busy_d = (state_q != IDLE);
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shreg_q[0];
      PARITY:  line_d = parity_q;
      default: line_d = 1'b1;
    endcase
  end

  // Line and busy are registered together so busy brackets exactly the bits on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_serial  <= 1'b1;
      tx_busy    <= 1'b0;
      shreg_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      parity_q   <= 1'b0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      tx_serial <= line_d;
      tx_busy   <= busy_d;
      if (pop) begin
        shreg_q    <= fifo_dat;
        bit_idx_q  <= '0;
        baud_cnt_q <= baud_div;
        parity_q   <= (^fifo_dat) ^ parity_odd;
        div_q      <= baud_div;
        par_en_q   <= parity_en;
        two_stop_q <= two_stop;
      end else if (state_q != IDLE) begin
        if (bit_end) begin
          baud_cnt_q <= div_q;
          if (state_q == DATA) begin
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + IW'(1);
          end
        end else begin
          baud_cnt_q <= baud_cnt_q - DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/xmit_uart_tx.md
Name: xmit_uart_tx

Overview:
Parametrised serial transmitter: the successor to the two-stage transmit path (load stage feeding shift stage). Accepts parallel words through a valid/ready handshake into an internal FIFO. Serialises each word as an asynchronous frame: start bit, DATA_W data bits LSB first, optional parity, then one or two stop bits. The bit period is runtime-programmable. Sits between the host-side data source and the external serial line driver.

Parameters:
DATA_W, 8, data bits per frame (5..9 supported)
FIFO_DEPTH, 4, number of queued words (power of two, >=2)
DIV_W, 16, width of the baud divisor

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  DATA_W  word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  FIFO can accept a word
baud_div  input  DIV_W  bit period minus one, in clk cycles
parity_en  input  1  1 = append parity bit
parity_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits, 0 = one
tx_serial  output  1  serial line, idles high
tx_busy  output  1  a frame is on the line
fifo_count  output  $clog2(FIFO_DEPTH)+1  words queued

Behaviour:
- Reset (rst=1 at clock edge): tx_serial=1, tx_busy=0, fifo_count=0, tx_ready=1 on the following cycle. FIFO is flushed. FSM goes to IDLE. Reset mid-frame aborts the frame; the line is high from the next cycle on.
- Handshake: a push occurs when tx_valid && tx_ready at a clock edge. tx_ready = (fifo_count != FIFO_DEPTH). There is no same-cycle bypass when full, so a push is refused when full even if a pop occurs in the same cycle. tx_data is ignored when tx_valid=0.
- Simultaneous push and pop: fifo_count is unchanged, and order is preserved.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START when the FIFO is non-empty. This pops the head into the shift register and latches baud_div, parity_en, parity_odd and two_stop. Config changes mid-frame have no effect.
  - START (line 0) -> DATA.
  - DATA outputs bit 0 first. After bit DATA_W-1 it goes to PARITY if parity_en, else STOP1.
  - PARITY -> STOP1.
  - STOP1 (line 1) -> STOP2 if two_stop. Otherwise, at the end of the period: START if the FIFO is non-empty (pop and re-latch), else IDLE.
  - STOP2 (line 1) follows the same exit rule as STOP1.
- Bit timing: each state from START onward lasts exactly baud_div+1 cycles, counted by a down-counter reloaded at each bit boundary. baud_div=0 gives 1 cycle per bit.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. The start bit is on tx_serial from edge N+2.
- Back-to-back frames: the next start bit immediately follows the last stop bit, with no idle cycle.
- Parity bit = XOR of data bits, inverted when parity_odd.
- tx_busy = 1 in every state except IDLE. It stays high continuously across back-to-back frames.
- Frame length in cycles = (baud_div+1) × (1 + DATA_W + parity_en + 1 + two_stop).
- tx_serial is registered (glitch-free).

Test Plan:
- Reset then idle, no pushes -> tx_serial=1, tx_busy=0, tx_ready=1, fifo_count=0 for 100 cycles.
- Basic frame: baud_div=3, DATA_W=8, no parity, one stop; push 0xA5 at edge 0 -> from edge 2, line = 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles); tx_busy high for exactly 40 cycles; then IDLE.
- Parity: 0xA5 with parity_en=1 -> parity bit 0 when even, 1 when odd; with two_stop=1, frame length is 12 bits = 48 cycles at baud_div=3.
- Backpressure: baud_div=100; push 6 words 0x01..0x06 with tx_valid held high -> tx_ready drops once fifo_count=4; word 0x06 is accepted only after the first frame pops the next word; all six frames are emitted in order with no gap between stop and start bits; tx_busy never drops.
- Config latch: change baud_div 3->7 and parity_en 0->1 mid-frame -> the current frame keeps 4-cycle bits and no parity; the next frame uses 8-cycle bits with parity.
- Reset mid-frame: assert rst during data bit 3 with 2 words queued -> next cycle tx_serial=1, fifo_count=0, tx_busy=0; nothing further is transmitted. Also check baud_div=0 with 0xFF -> 10-cycle frame, 1 cycle per bit.
